list_summary_collector: RTL and testbench
=========================================

Name: list_summary_collector

Overview:
- Sits directly downstream of the pointer-sequence generator and consumes its out_ptr/out_ptr_vld stream. That stream has no backpressure.
- Splits the stream into lists. A list is a maximal run of consecutive valid cycles.
- Produces one summary record per list: head, tail, length and loop flag.
- Records are buffered in a small FIFO and drained over a valid/ready handshake.

Parameters:
- n, 16: number of list nodes; pointer 0 is null.
- Width, $clog2(n): pointer width.
- LenW, $clog2(n+1): length field width; holds 0..n.
- FifoDepth, 4: summary FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- in_ptr  in  Width  pointer from upstream.
- in_ptr_vld  in  1  in_ptr valid; no ready is returned.
- sum_head  out  Width  first pointer of the list.
- sum_tail  out  Width  last pointer of the list.
- sum_len  out  LenW  node count, saturating at n.
- sum_loop  out  1  a pointer repeated within the list.
- sum_vld  out  1  record at FIFO head is valid.
- sum_rdy  in  1  consumer accepts the record.
- overflow  out  1  sticky: at least one record was dropped.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state IDLE; FIFO empty; visited bitmap cleared.
  - sum_vld=0, overflow=0.
  - sum_head, sum_tail, sum_len, sum_loop = 0.
- Record fields are driven from the FIFO head entry; their values are don't-care while sum_vld=0.
- FSM states: IDLE, ACCUM.
- IDLE:
  - in_ptr_vld=1 and in_ptr!=0: capture head=tail=in_ptr, len=1, loop=0; visited = one-hot(in_ptr); go to ACCUM.
  - in_ptr_vld=1 and in_ptr==0: ignored; stay in IDLE.
  - in_ptr_vld=0: stay in IDLE.
- ACCUM, in_ptr_vld=1:
  - tail=in_ptr; len=min(len+1, n).
  - If visited[in_ptr] is set, loop=1.
  - Set visited[in_ptr].
  - in_ptr==0 is counted like any other pointer; upstream never emits it.
- ACCUM, in_ptr_vld=0 (commit):
  - At this edge, push {head, tail, len, loop} into the FIFO and go to IDLE.
  - visited is cleared on the next capture.
- Latency: an entry pushed into an empty FIFO makes sum_vld=1 in the cycle after the commit edge. With back-to-back lists, this is the same cycle in which the next list may start.
- Handshake:
  - Pop when sum_vld & sum_rdy.
  - A record stays stable while sum_vld=1 and sum_rdy=0.
  - sum_vld never drops without a pop.
- Simultaneous push and pop: both happen; occupancy is unchanged. This is legal when the FIFO is full, because the pop frees a slot in the same cycle.
- Full FIFO at commit with no pop that cycle:
  - The record is dropped and overflow is set.
  - overflow stays set until rst.
  - The FIFO contents are unaffected.
- FIFO pointers are log2(FifoDepth)+1 bits with natural wrap-around; full/empty are decided by the MSB comparison.
- Lists have no maximum length; len saturates at n.
- More than n valid cycles in one list implies a repeat, so loop=1.
- rst mid-list: the partial list is discarded; no record is emitted.
- rst with a non-empty FIFO: all entries are lost.
- The block never stalls input; every input cycle is consumed.

Test Plan:
- in_ptr 7,15,8 (vld=1), then vld=0, sum_rdy=1 -> one cycle after the commit: sum_vld=1, head=7, tail=8, len=3, loop=0; popped the same cycle.
- Single pointer 6, then a gap; then 2,4, then a gap; sum_rdy=1 -> records {6,6,1,0} then {2,4,2,0}, in order.
- in_ptr 3,5,3,10, then a gap -> record {3,10,4,1}.
- sum_rdy=0; five lists 1/2/6/7/9, each one node long with single-cycle gaps -> the FIFO holds 1,2,6,7 and overflow=1. Then sum_rdy=1 -> exactly four records drain, sum_vld=0 afterwards, overflow stays 1.
- 20 consecutive valid cycles cycling pointers 1..15 -> len=16 (saturated), loop=1, tail=5.
- Start list 9,14,11, assert rst mid-list, deassert, then stream 12 and a gap -> only record {12,12,1,0} appears; overflow=0.

Source files
------------

// File: rtl/list_summary_collector.sv
// Splits a no-backpressure pointer stream into lists (runs of valid cycles) and
// queues one {head, tail, len, loop} summary per list for a valid/ready consumer.
module list_summary_collector #(
    parameter int n         = 16,
    parameter int Width     = $clog2(n),
    parameter int LenW      = $clog2(n + 1),
    parameter int FifoDepth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [Width-1:0] in_ptr,
    input  logic             in_ptr_vld,
    output logic [Width-1:0] sum_head,
    output logic [Width-1:0] sum_tail,
    output logic [LenW-1:0]  sum_len,
    output logic             sum_loop,
    output logic             sum_vld,
    input  logic             sum_rdy,
    output logic             overflow
);

    localparam int AW   = $clog2(FifoDepth);
    localparam int RecW = 2 * Width + LenW + 1;

    // sum_vld/sum_rdy: a record transfers on any edge where both are high;
    // while sum_vld=1 and sum_rdy=0 the record is held stable.

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state_q, state_d;
    logic [Width-1:0] head_q, head_d;
    logic [Width-1:0] tail_q, tail_d;
    logic [LenW-1:0]  len_q, len_d;
    logic             loop_q, loop_d;
    logic [n-1:0]     visited_q, visited_d;
    logic [RecW-1:0]  mem_q [FifoDepth];
    logic [RecW-1:0]  mem_d [FifoDepth];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             overflow_q, overflow_d;

    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full;
    logic [RecW-1:0] head_rec;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop        = !fifo_empty && sum_rdy;

    always_comb begin
        state_d    = state_q;
        head_d     = head_q;
        tail_d     = tail_q;
        len_d      = len_q;
        loop_d     = loop_q;
        visited_d  = visited_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        push       = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_ptr_vld && (in_ptr != '0)) begin
                    head_d            = in_ptr;
                    tail_d            = in_ptr;
                    len_d             = LenW'(1);
                    loop_d            = 1'b0;
                    visited_d         = '0;
                    visited_d[in_ptr] = 1'b1;
                    state_d           = ACCUM;
                end
            end
            ACCUM: begin
                if (in_ptr_vld) begin
                    tail_d = in_ptr;
                    if (len_q != LenW'(n)) begin
                        len_d = len_q + LenW'(1);
                    end
                    if (visited_q[in_ptr]) begin
                        loop_d = 1'b1;
                    end
                    visited_d[in_ptr] = 1'b1;
                end else begin
                    push    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // A pop in the same cycle frees the slot, so a full FIFO still accepts.
        if (push) begin
            if (!fifo_full || pop) begin
                mem_d[wr_ptr_q[AW-1:0]] = {head_q, tail_q, len_q, loop_q};
                wr_ptr_d                = wr_ptr_q + 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            head_q     <= '0;
            tail_q     <= '0;
            len_q      <= '0;
            loop_q     <= 1'b0;
            visited_q  <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
            for (int i = 0; i < FifoDepth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            len_q      <= len_d;
            loop_q     <= loop_d;
            visited_q  <= visited_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
            mem_q      <= mem_d;
        end
    end

    assign head_rec = mem_q[rd_ptr_q[AW-1:0]];
    assign sum_head = head_rec[RecW-1 -: Width];
    assign sum_tail = head_rec[RecW-1-Width -: Width];
    assign sum_len  = head_rec[LenW:1];
    assign sum_loop = head_rec[0];
    assign sum_vld  = !fifo_empty;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_list_summary_collector.sv
// Directed bench for list_summary_collector: drivers push expected records into
// exp_q, an independent monitor pops and compares on every handshake.
module tb_list_summary_collector;

    localparam int N  = 16;
    localparam int W  = 4;
    localparam int LW = 5;
    localparam int RW = 2 * W + LW + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  in_ptr;
    logic          in_ptr_vld;
    logic [W-1:0]  sum_head;
    logic [W-1:0]  sum_tail;
    logic [LW-1:0] sum_len;
    logic          sum_loop;
    logic          sum_vld;
    logic          sum_rdy;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    logic [RW-1:0] exp_q[$];

    list_summary_collector #(.n(N), .FifoDepth(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_ptr    (in_ptr),
        .in_ptr_vld(in_ptr_vld),
        .sum_head  (sum_head),
        .sum_tail  (sum_tail),
        .sum_len   (sum_len),
        .sum_loop  (sum_loop),
        .sum_vld   (sum_vld),
        .sum_rdy   (sum_rdy),
        .overflow  (overflow)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // checking helpers
    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_rec(input int h, input int t, input int l, input int lp);
        exp_q.push_back({W'(h), W'(t), LW'(l), 1'(lp)});
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        if (!rst && sum_vld && sum_rdy) begin
            logic [RW-1:0] act;
            logic [RW-1:0] exp;
            act = {sum_head, sum_tail, sum_len, sum_loop};
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_record: got h=%0d t=%0d len=%0d loop=%0d, expected none",
                         sum_head, sum_tail, sum_len, sum_loop);
            end else begin
                exp = exp_q.pop_front();
                if (act !== exp) begin
                    errors++;
                    $display("FAIL record: got h=%0d t=%0d len=%0d loop=%0d, expected h=%0d t=%0d len=%0d loop=%0d",
                             sum_head, sum_tail, sum_len, sum_loop,
                             exp[RW-1 -: W], exp[RW-1-W -: W], exp[LW:1], exp[0]);
                end
            end
        end
    end

    // driver tasks
    task automatic drive_ptr(input int p);
        in_ptr     = W'(p);
        in_ptr_vld = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        in_ptr     = '0;
        in_ptr_vld = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && (exp_q.size() != 0 || sum_vld); i++) begin
            gap();
        end
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_sum_vld", int'(sum_vld), 0);
    endtask

    initial begin
        rst        = 1'b1;
        in_ptr     = '0;
        in_ptr_vld = 1'b0;
        sum_rdy    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sum_vld", int'(sum_vld), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_sum_head", int'(sum_head), 0);
        check("reset_sum_tail", int'(sum_tail), 0);
        check("reset_sum_len", int'(sum_len), 0);
        check("reset_sum_loop", int'(sum_loop), 0);
        rst = 1'b0;
        gap();

        // basic list with latency check
        expect_rec(7, 8, 3, 0);
        drive_ptr(7);
        drive_ptr(15);
        drive_ptr(8);
        check("pre_commit_sum_vld", int'(sum_vld), 0);
        gap();
        check("post_commit_sum_vld", int'(sum_vld), 1);
        wait_drain();

        // single node, then two nodes
        expect_rec(6, 6, 1, 0);
        expect_rec(2, 4, 2, 0);
        drive_ptr(6);
        gap();
        drive_ptr(2);
        drive_ptr(4);
        gap();
        wait_drain();

        // repeat inside list
        expect_rec(3, 10, 4, 1);
        drive_ptr(3);
        drive_ptr(5);
        drive_ptr(3);
        drive_ptr(10);
        gap();
        wait_drain();

        // back-to-back lists, no gap between commit and next start
        expect_rec(11, 11, 1, 0);
        expect_rec(12, 13, 2, 0);
        drive_ptr(11);
        gap();
        drive_ptr(12);
        drive_ptr(13);
        gap();
        wait_drain();

        // fill FIFO with no consumer, fifth record dropped
        sum_rdy = 1'b0;
        expect_rec(1, 1, 1, 0);
        expect_rec(2, 2, 1, 0);
        expect_rec(6, 6, 1, 0);
        expect_rec(7, 7, 1, 0);
        drive_ptr(1);
        gap();
        check("hold_overflow_before_full", int'(overflow), 0);
        drive_ptr(2);
        gap();
        drive_ptr(6);
        gap();
        drive_ptr(7);
        gap();
        check("full_overflow_clear", int'(overflow), 0);
        drive_ptr(9);
        gap();
        gap();
        check("overflow_set", int'(overflow), 1);
        check("hold_sum_vld", int'(sum_vld), 1);
        check("hold_sum_head", int'(sum_head), 1);
        sum_rdy = 1'b1;
        wait_drain();
        check("overflow_sticky", int'(overflow), 1);

        // long list: saturation and implied loop
        expect_rec(1, 5, 16, 1);
        for (int i = 0; i < 20; i++) begin
            drive_ptr((i % 15) + 1);
        end
        gap();
        wait_drain();

        // reset mid-list discards partial list and clears overflow
        drive_ptr(9);
        drive_ptr(14);
        drive_ptr(11);
        rst        = 1'b1;
        in_ptr_vld = 1'b0;
        in_ptr     = '0;
        @(posedge clk);
        #1;
        check("midrst_overflow", int'(overflow), 0);
        check("midrst_sum_vld", int'(sum_vld), 0);
        rst = 1'b0;
        gap();
        check("after_rst_sum_vld", int'(sum_vld), 0);
        expect_rec(12, 12, 1, 0);
        drive_ptr(12);
        gap();
        wait_drain();
        check("final_overflow", int'(overflow), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
